hazard_scoreboard: RTL and testbench

- Parametrised successor to the two-instruction pairwise conflict check.
- Tracks the destination registers of the DEPTH instructions in flight downstream of decode (EX, MA, RW, ...) in a shift-register scoreboard.
- For each decode-stage instruction, it resolves both source operands against the scoreboard and emits per-operand forwarding selects (nearest producer wins).
- It also generates the load-use stall, honours pipeline freeze and flush, and keeps a saturating stall counter.

---
 rtl/hazard_scoreboard.sv | 158 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard with operand forwarding selects and load-use stall
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int LD_FWD_MIN = 2,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             advance,
    input  logic             flush,
    output logic             stall,
    output logic [SELW-1:0]  fwd_sel_a,
    output logic [SELW-1:0]  fwd_sel_b,
    output logic             conflict_a,
    output logic             conflict_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    logic [4:0] op;
    logic       imm;
    logic [3:0] rd, rs1, rs2;
    logic       unused_bits;

    assign op          = id_inst[31:27];
    assign imm         = id_inst[26];
    assign rd          = id_inst[25:22];
    assign rs1         = id_inst[21:18];
    assign rs2         = id_inst[17:14];
    assign unused_bits = ^id_inst[13:0];

    logic       use_a, use_b, has_dest, is_load;
    logic [3:0] src_a, src_b, dest;
    logic       is_alu;

    always_comb begin
        use_a    = 1'b0;
        use_b    = 1'b0;
        src_a    = rs1;
        src_b    = rs2;
        has_dest = 1'b0;
        dest     = rd;
        is_load  = 1'b0;
        is_alu   = 1'b0;
        case (op)
            OP_NOP, OP_B, OP_BEQ, OP_BGT: ;
            OP_CALL: begin
                has_dest = 1'b1;
                dest     = 4'hF;
            end
            OP_RET: begin
                use_a = 1'b1;
                src_a = 4'hF;
            end
            OP_NOT, OP_MOV: begin
                use_b    = !imm;
                has_dest = 1'b1;
            end
            OP_CMP: begin
                use_a = 1'b1;
                use_b = !imm;
            end
            OP_ST: begin
                use_a = 1'b1;
                use_b = 1'b1;
                src_b = rd;
            end
            OP_LD: begin
                use_a    = 1'b1;
                has_dest = 1'b1;
                is_load  = 1'b1;
            end
            default: is_alu = 1'b1;
        endcase
        if (is_alu) begin
            use_a    = 1'b1;
            use_b    = !imm;
            has_dest = 1'b1;
        end
    end

    logic [DEPTH:1] sb_v;
    logic [DEPTH:1] sb_ld;
    logic [3:0]     sb_dest [DEPTH:1];

    logic [SELW-1:0] sel_a, sel_b;
    logic            ld_hit_a, ld_hit_b;

    // Walk oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        ld_hit_a = 1'b0;
        ld_hit_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb_v[k] && sb_dest[k] == src_a) begin
                sel_a    = SELW'(k);
                ld_hit_a = sb_ld[k] && (k < LD_FWD_MIN);
            end
            if (sb_v[k] && sb_dest[k] == src_b) begin
                sel_b    = SELW'(k);
                ld_hit_b = sb_ld[k] && (k < LD_FWD_MIN);
            end
        end
        if (!id_valid || !use_a) begin
            sel_a    = '0;
            ld_hit_a = 1'b0;
        end
        if (!id_valid || !use_b) begin
            sel_b    = '0;
            ld_hit_b = 1'b0;
        end
    end

    assign fwd_sel_a  = sel_a;
    assign fwd_sel_b  = sel_b;
    assign conflict_a = (sel_a != '0);
    assign conflict_b = (sel_b != '0);
    assign stall      = id_valid && !flush && (ld_hit_a || ld_hit_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v        <= '0;
            stall_count <= '0;
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_v[k]    <= sb_v[k-1];
                sb_ld[k]   <= sb_ld[k-1];
                sb_dest[k] <= sb_dest[k-1];
            end
            if (stall || flush || !id_valid) begin
                sb_v[1]  <= 1'b0;
                sb_ld[1] <= 1'b0;
            end else begin
                sb_v[1]  <= has_dest;
                sb_ld[1] <= is_load;
            end
            sb_dest[1] <= dest;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        advance;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        conflict_a, conflict_b;
    logic [3:0]  stall_count;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SUB  = 5'b00001;
    localparam logic [4:0] MOV  = 5'b01001;
    localparam logic [4:0] LD   = 5'b01110;
    localparam logic [4:0] ST   = 5'b01111;
    localparam logic [4:0] CALL = 5'b10011;
    localparam logic [4:0] RET  = 5'b10100;

    hazard_scoreboard #(.DEPTH(3), .LD_FWD_MIN(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
        .advance(advance), .flush(flush), .stall(stall),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .conflict_a(conflict_a), .conflict_b(conflict_b),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [4:0] op, input logic i,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2);
        return {op, i, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst);
        id_valid = v;
        id_inst  = inst;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic s);
        chk({tag, ".sel_a"}, 32'(fwd_sel_a), 32'(a));
        chk({tag, ".sel_b"}, 32'(fwd_sel_b), 32'(b));
        chk({tag, ".stall"}, 32'(stall), 32'(s));
    endtask

    initial begin
        rst = 1'b1; advance = 1'b1; flush = 1'b0;
        drive(1'b0, 32'd0);
        tick; tick;
        rst = 1'b0;
        drive(1'b0, 32'd0);
        chk_sel("reset", 2'd0, 2'd0, 1'b0);
        chk("reset.count", 32'(stall_count), 32'd0);

        // producer then dependent consumer
        drive(1'b1, ins(ADD, 1'b0, 4'd3, 4'd1, 4'd2));
        chk_sel("add_r3", 2'd0, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(SUB, 1'b0, 4'd5, 4'd3, 4'd4));
        chk_sel("sub_dep", 2'd1, 2'd0, 1'b0);
        chk("sub_dep.conf_a", 32'(conflict_a), 32'd1);
        chk("sub_dep.conf_b", 32'(conflict_b), 32'd0);
        tick;

        // load-use: one stall cycle, then forward from entry 2
        drive(1'b1, ins(LD, 1'b1, 4'd2, 4'd0, 4'd0));
        chk_sel("ld_r2", 2'd0, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(ADD, 1'b0, 4'd6, 4'd2, 4'd2));
        chk_sel("ldu_stall", 2'd1, 2'd1, 1'b1);
        chk("ldu_stall.count", 32'(stall_count), 32'd0);
        tick;
        chk_sel("ldu_fwd", 2'd2, 2'd2, 1'b0);
        chk("ldu_fwd.count", 32'(stall_count), 32'd1);
        tick;

        // duplicate destination: youngest wins
        drive(1'b1, ins(ADD, 1'b0, 4'd7, 4'd8, 4'd9));
        tick;
        drive(1'b1, ins(ADD, 1'b0, 4'd7, 4'd8, 4'd9));
        chk_sel("add_r7_2", 2'd0, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(ST, 1'b0, 4'd7, 4'd1, 4'd0));
        chk_sel("st_dup", 2'd0, 2'd1, 1'b0);
        chk("st_dup.conf_a", 32'(conflict_a), 32'd0);
        tick;

        // CALL/RET link register and immediate gating
        drive(1'b1, ins(CALL, 1'b0, 4'd0, 4'd0, 4'd0));
        chk_sel("call", 2'd0, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(RET, 1'b0, 4'd0, 4'd0, 4'd0));
        chk_sel("ret", 2'd1, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(MOV, 1'b1, 4'd2, 4'd0, 4'd0));
        chk_sel("mov_imm", 2'd0, 2'd0, 1'b0);
        tick;
        drive(1'b1, ins(ADD, 1'b1, 4'd1, 4'd2, 4'd2));
        chk_sel("add_imm", 2'd1, 2'd0, 1'b0);
        tick;

        // freeze: entries and selects hold for 3 cycles
        advance = 1'b0;
        drive(1'b1, ins(SUB, 1'b0, 4'd9, 4'd1, 4'd2));
        for (int c = 0; c < 3; c++) begin
            chk_sel($sformatf("freeze%0d", c), 2'd1, 2'd2, 1'b0);
            tick;
        end
        chk_sel("freeze_end", 2'd1, 2'd2, 1'b0);
        chk("freeze.count", 32'(stall_count), 32'd1);
        advance = 1'b1;
        drive(1'b1, ins(LD, 1'b1, 4'd4, 4'd0, 4'd0));
        chk_sel("ld_r4", 2'd0, 2'd0, 1'b0);
        tick;

        // pending stall under freeze holds stall and counter
        advance = 1'b0;
        drive(1'b1, ins(ADD, 1'b0, 4'd10, 4'd4, 4'd0));
        chk_sel("frz_stall", 2'd1, 2'd0, 1'b1);
        tick;
        chk_sel("frz_stall2", 2'd1, 2'd0, 1'b1);
        chk("frz_stall.count", 32'(stall_count), 32'd1);

        // flush suppresses the stall and inserts a bubble
        advance = 1'b1;
        flush   = 1'b1;
        #1;
        chk_sel("flush", 2'd1, 2'd0, 1'b0);
        tick;
        flush = 1'b0;
        drive(1'b1, ins(ADD, 1'b0, 4'd11, 4'd10, 4'd4));
        chk_sel("post_flush", 2'd0, 2'd2, 1'b0);
        chk("post_flush.count", 32'(stall_count), 32'd1);
        tick;

        // repeated load-use drives the counter into saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, ins(LD, 1'b1, 4'd4, 4'd0, 4'd0));
            tick;
            drive(1'b1, ins(ADD, 1'b0, 4'd10, 4'd4, 4'd0));
            if (i == 13)
                chk("sat_reach.count", 32'(stall_count), 32'd14);
            tick;
        end
        chk("sat.count", 32'(stall_count), 32'd15);

        // reset mid-run clears entries and counter
        drive(1'b1, ins(ADD, 1'b0, 4'd10, 4'd4, 4'd4));
        chk_sel("pre_rst", 2'd2, 2'd2, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk_sel("post_rst", 2'd0, 2'd0, 1'b0);
        chk("post_rst.count", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
